serial_bus_arbiter: RTL and testbench

Arbitrates ownership of the shared serial address/data bus between up to NUM_MASTERS bus masters, such as the UART bridge, each of which raises a request line and drives the bus only while its ready line is high. The block grants one master at a time, holds the grant until that master drops its request, and can preempt long transfers. Preempted masters already pause and resume when their ready line drops. The block sits at the top level between all master request lines and the bus fabric.

---
 rtl/serial_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Shared serial bus arbiter: one-at-a-time grant, hold until release, timeout preemption.
// Optional macro ROUND_ROBIN_EN selects rotating priority; default build is fixed lowest-index priority.
module serial_bus_arbiter #(
   parameter int unsigned      NUM_MASTERS = 3,
   parameter int unsigned      CNT_W       = 10,
   parameter logic [CNT_W-1:0] MAX_GRANT   = 10'd64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] bus_req,
   output logic [NUM_MASTERS-1:0] bus_ready,
   output logic [2:0]             grant_id,
   output logic                   bus_busy,
   output logic                   preempt
);

   localparam int unsigned      ID_W       = 3;
   localparam bit               PREEMPT_EN = (MAX_GRANT != '0);
   localparam logic [CNT_W-1:0] CNT_ONES   = '1;
   // With preemption on, the counter parks at the timeout value so a late contender still preempts.
   localparam logic [CNT_W-1:0] CNT_SAT    = PREEMPT_EN ? (MAX_GRANT - CNT_W'(1)) : CNT_ONES;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      HANDOVER = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        owner, owner_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [NUM_MASTERS-1:0] excl, excl_nxt;
   logic                   preempt_nxt;
   logic                   take;

   logic [NUM_MASTERS-1:0] cand;
   logic [ID_W-1:0]        win;
   logic                   win_vld;
   logic                   own_req;
   logic                   others_req;
   logic [NUM_MASTERS-1:0] ready_nxt;

   // Candidates: excluded master drops out unless it is the only requester.
   always_comb begin
      cand = bus_req & ~excl;
      if (cand == '0) begin
         cand = bus_req;
      end
   end

`ifdef ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr;

   // Closest set candidate at or above the pointer, wrapping.
   always_comb begin
      int best_d;
      int d;
      win     = '0;
      win_vld = 1'b0;
      best_d  = int'(NUM_MASTERS);
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         d = i - int'(rr_ptr);
         if (d < 0) begin
            d = d + int'(NUM_MASTERS);
         end
         if (cand[i] && (d < best_d)) begin
            best_d  = d;
            win     = ID_W'(i);
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (take) begin
         if ((int'(win) + 1) >= int'(NUM_MASTERS)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= win + ID_W'(1);
         end
      end
   end
`else
   // Lowest set candidate wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win     = ID_W'(i);
            win_vld = 1'b1;
         end
      end
   end
`endif

   // In GRANT, bus_ready is exactly the owner's one-hot mask.
   assign own_req    = |(bus_req & bus_ready);
   assign others_req = |(bus_req & ~bus_ready);

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      cnt_nxt     = cnt;
      excl_nxt    = excl;
      preempt_nxt = 1'b0;
      take        = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt = GRANT;
               owner_nxt = win;
               cnt_nxt   = '0;
               take      = 1'b1;
            end
         end
         GRANT: begin
            if (!own_req) begin
               state_nxt = HANDOVER;
               cnt_nxt   = '0;
            end else if (PREEMPT_EN && (cnt == CNT_SAT) && others_req) begin
               state_nxt   = HANDOVER;
               cnt_nxt     = '0;
               preempt_nxt = 1'b1;
               excl_nxt    = bus_ready;
            end else if (cnt != CNT_SAT) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HANDOVER: begin
            excl_nxt = '0;
            if (win_vld) begin
               state_nxt = GRANT;
               owner_nxt = win;
               cnt_nxt   = '0;
               take      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            excl_nxt  = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      ready_nxt = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         ready_nxt[i] = (state_nxt == GRANT) && (owner_nxt == ID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= '0;
         cnt       <= '0;
         excl      <= '0;
         bus_ready <= '0;
         grant_id  <= '0;
         bus_busy  <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         cnt       <= cnt_nxt;
         excl      <= excl_nxt;
         bus_ready <= ready_nxt;
         grant_id  <= (state_nxt == GRANT) ? owner_nxt : '0;
         bus_busy  <= (state_nxt == GRANT);
         preempt   <= preempt_nxt;
      end
   end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed scenarios plus randomized traffic vs. a cycle-count model.
module tb_serial_bus_arbiter;

   localparam int unsigned N    = 3;
   localparam int unsigned CW   = 10;
   localparam int          MAXG = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] bus_req;
   logic [N-1:0] bus_ready;
   logic [2:0]   grant_id;
   logic         bus_busy;
   logic         preempt;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index, phase (0 idle, 1 owned, 2 gap), cycles owned so far.
   int m_owner;
   int m_phase;
   int m_held;
   int m_excl;
   int m_ptr;
   bit m_pre;

   serial_bus_arbiter #(
      .NUM_MASTERS(N),
      .CNT_W      (CW),
      .MAX_GRANT  (10'd8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus_req  (bus_req),
      .bus_ready(bus_ready),
      .grant_id (grant_id),
      .bus_busy (bus_busy),
      .preempt  (preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_phase = 0;
      m_held  = 0;
      m_excl  = -1;
      m_ptr   = 0;
      m_pre   = 1'b0;
   endtask

   function automatic int choose(input logic [N-1:0] r, input int ex);
      logic [N-1:0] c;
      c = r;
      if (ex >= 0) c = r & ~(N'(1) << ex);
      if (c == '0) c = r;
`ifdef ROUND_ROBIN_EN
      for (int k = 0; k < int'(N); k++) begin
         int i;
         i = (m_ptr + k) % int'(N);
         if (c[i]) return i;
      end
`else
      for (int i = 0; i < int'(N); i++) begin
         if (c[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic start_grant(input logic [N-1:0] r, input int ex);
      m_owner = choose(r, ex);
      m_ptr   = (m_owner + 1) % int'(N);
      m_held  = 1;
      m_phase = 1;
   endtask

   task automatic model_update(input logic [N-1:0] r);
      logic [N-1:0] others;
      m_pre = 1'b0;
      case (m_phase)
         0: if (r != '0) start_grant(r, -1);
         1: begin
            others = r & ~(N'(1) << m_owner);
            if (!r[m_owner]) begin
               m_owner = -1;
               m_phase = 2;
               m_excl  = -1;
            end else if ((MAXG != 0) && (m_held >= MAXG) && (others != '0)) begin
               m_excl  = m_owner;
               m_owner = -1;
               m_phase = 2;
               m_pre   = 1'b1;
            end else begin
               m_held++;
            end
         end
         default: begin
            if (r != '0) start_grant(r, m_excl);
            else m_phase = 0;
            m_excl = -1;
         end
      endcase
   endtask

   task automatic compare();
      logic [N-1:0] er;
      er = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("ready", 32'(bus_ready), 32'(er));
      check("gid",   32'(grant_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("busy",  32'(bus_busy),  32'(m_owner >= 0));
      check("pre",   32'(preempt),   32'(m_pre));
   endtask

   task automatic step();
      @(posedge clk);
      model_update(bus_req);
      #1;
      compare();
   endtask

   task automatic go_idle();
      bus_req = '0;
      repeat (3) step();
   endtask

   initial begin
      int ones;
      int pres;
      logic [N-1:0] r;

      model_reset();
      reset   = 1'b0;
      bus_req = '0;
      #12;
      check("rst_ready", 32'(bus_ready), 32'd0);
      check("rst_gid",   32'(grant_id),  32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Reset mid-grant, then request from master 1 again.
      bus_req = 3'b010;
      step();
      step();
      check("own1", 32'(bus_ready), 32'b010);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("async_ready", 32'(bus_ready), 32'd0);
      check("async_gid",   32'(grant_id),  32'd0);
      check("async_busy",  32'(bus_busy),  32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("post_rst_grant", 32'(bus_ready), 32'b010);
      go_idle();

      // Simultaneous requests in priority order with one dead cycle between owners.
      bus_req = 3'b111;
      step(); check("sim_g0", 32'(bus_ready), 32'b001);
      bus_req = 3'b110;
      step(); check("sim_gap0", 32'(bus_ready), 32'b000);
      step(); check("sim_g1", 32'(bus_ready), 32'b010);
      bus_req = 3'b100;
      step(); check("sim_gap1", 32'(bus_ready), 32'b000);
      step(); check("sim_g2", 32'(bus_ready), 32'b100);
      go_idle();

      // Preemption: master 0 holds, master 2 arrives at grant cycle 3.
      bus_req = 3'b001;
      step();
      ones = 1;
      pres = 0;
      repeat (2) begin
         step();
         if (bus_ready[0]) ones++;
      end
      bus_req = 3'b101;
      repeat (10) begin
         step();
         if (bus_ready[0]) ones++;
         if (preempt) pres++;
      end
      check("pre_hold_cycles", 32'(ones), 32'd8);
      check("pre_pulses",      32'(pres), 32'd1);
      check("pre_new_owner",   32'(bus_ready), 32'b100);
      bus_req = 3'b001;
      step(); check("pre_gap", 32'(bus_ready), 32'b000);
      step(); check("pre_regrant0", 32'(bus_ready), 32'b001);
      go_idle();

      // No contention: a lone owner is never preempted.
      bus_req = 3'b010;
      step();
      ones = 0;
      pres = 0;
      repeat (50) begin
         step();
         if (bus_ready == 3'b010) ones++;
         if (preempt) pres++;
      end
      check("solo_hold", 32'(ones), 32'd50);
      check("solo_pre",  32'(pres), 32'd0);
      go_idle();

      // Release on the timeout cycle is a plain release.
      bus_req = 3'b001;
      step();
      bus_req = 3'b101;
      repeat (7) step();
      bus_req = 3'b100;
      step();
      check("rel_to_pre",   32'(preempt),   32'd0);
      check("rel_to_gap",   32'(bus_ready), 32'b000);
      step();
      check("rel_to_owner", 32'(bus_ready), 32'b100);
      go_idle();

      // Randomized traffic: masters hold requests for random spans.
      r = '0;
      repeat (3000) begin
         for (int i = 0; i < int'(N); i++) begin
            if (!r[i]) begin
               if ($urandom_range(3) == 0) r[i] = 1'b1;
            end else if (i == m_owner) begin
               if ($urandom_range(11) == 0) r[i] = 1'b0;
            end else begin
               if ($urandom_range(23) == 0) r[i] = 1'b0;
            end
         end
         bus_req = r;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
